univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register. Supports hold, shift right, shift left
//   and parallel load, with serial I/O at both ends and parallel I/O.
//   Counts shifts so a frame-complete pulse marks each WIDTH-bit serial word.
//   Serves as the common SISO/SIPO/PISO/PIPO primitive for the serial datapath.
// PARAMETERS
//   WIDTH    8   register width in bits; legal range >= 2
//   RST_VAL  0   WIDTH-bit value loaded into q on reset
// PORTS
//   clk         in   1              rising-edge clock
//   rst         in   1              reset, asynchronous, active-high
//   en          in   1              clock enable; 0 = hold everything
//   mode        in   2              00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r       in   1              serial input that enters q[WIDTH-1] on a right shift
//   sin_l       in   1              serial input that enters q[0] on a left shift
//   pin         in   WIDTH          parallel load data
//   pout        out  WIDTH          register contents q
//   sout_r      out  1              q[0]; serial output for right shifts
//   sout_l      out  1              q[WIDTH-1]; serial output for left shifts
//   shift_cnt   out  $clog2(WIDTH)  shifts completed in the current frame
//   frame_done  out  1              one-cycle pulse when a WIDTH-shift frame completes
// BEHAVIOUR
//   - Reset (async, active-high):
//       q=RST_VAL, shift_cnt=0, frame_done=0, last_dir=right.
//       Reset takes effect immediately, including mid-frame. Any partial frame is discarded.
//   - Every register updates on the rising clk edge only, and only when en=1.
//   - en=0: q, shift_cnt and last_dir hold. frame_done is forced to 0 at each edge.
//   - mode 00 (hold): q holds, shift_cnt holds, frame_done<=0.
//   - mode 01 (shift right): q <= {sin_r, q[WIDTH-1:1]}.
//   - mode 10 (shift left): q <= {q[WIDTH-2:0], sin_l}.
//   - mode 11 (load): q<=pin, shift_cnt<=0, frame_done<=0. last_dir is unchanged.
//   - Shift counting applies on each shift edge (mode 01/10, en=1):
//       dir = this shift's direction.
//       If shift_cnt!=0 and dir!=last_dir, the frame restarts: shift_cnt<=1, frame_done<=0.
//       Else if shift_cnt==WIDTH-1: shift_cnt<=0, frame_done<=1 (WIDTH-th shift).
//       Else: shift_cnt<=shift_cnt+1, frame_done<=0.
//       last_dir<=dir in all three cases.
//   - frame_done is registered. It goes high on the edge of the WIDTH-th shift and is
//     cleared on the next edge unless that edge also completes a frame.
//     With continuous shifting it pulses once every WIDTH cycles.
//   - shift_cnt wraps WIDTH-1 -> 0. It never reaches WIDTH.
//   - Serial latency: a bit on sin_r appears on sout_r after exactly WIDTH right-shift edges.
//     The same holds for sin_l to sout_l with left shifts.
//   - Outputs are pure functions of registered state; there is no combinational input->output path.
//   - mode is fully decoded; there are no illegal encodings.
// TESTING (WIDTH=4, RST_VAL=0 unless stated)
//   1. Reset
//      Stimulus: assert rst between clock edges.
//      Required: pout=0000, shift_cnt=0, frame_done=0 before the next edge.
//      With RST_VAL=4'hA: pout=1010.
//   2. SISO/SIPO right
//      Stimulus: en=1, mode=01, sin_r=1,0,1,1 over 4 edges.
//      Required: pout=1101 and frame_done=1 after edge 4, frame_done=0 after edge 5.
//      sout_r shows the first bit (1) after edge 4.
//   3. PISO left
//      Stimulus: load pin=1001, then mode=10, sin_l=0.
//      Required: sout_l=1,0,0,1 over 4 edges, pout=0000 after the 4th shift,
//      frame_done pulses once.
//   4. Direction change
//      Stimulus: 2 right shifts (shift_cnt=2), then 1 left shift.
//      Required: shift_cnt=1, frame_done stays 0. frame_done fires only after
//      3 more left shifts.
//   5. Enable and load
//      Stimulus: en=0 with mode=01 for 3 edges.
//      Required: pout and shift_cnt unchanged.
//      Stimulus: load mid-frame (shift_cnt=3).
//      Required: shift_cnt=0, no frame_done.
//   6. Reset mid-frame
//      Stimulus: assert rst after 3 right shifts, release, then shift 4 bits.
//      Required: frame_done fires only on the 4th post-reset shift.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for the universal shift register: control, serial and
// parallel data inputs plus all register-derived outputs.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
) ();
  localparam int CNT_W = $clog2(WIDTH);

  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] shift_cnt;
  logic             frame_done;

  // Driver side (stimulus / upstream logic).
  modport master (
    output en, mode, sin_r, sin_l, pin,
    input  pout, sout_r, sout_l, shift_cnt, frame_done
  );

  // Register side.
  modport slave (
    input  en, mode, sin_r, sin_l, pin,
    output pout, sout_r, sout_l, shift_cnt, frame_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// A frame counter tracks consecutive same-direction shifts and raises a
// one-cycle frame_done pulse on every WIDTH-th shift of a frame. A change
// of shift direction mid-frame restarts the frame at count 1.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic             clk,
  input logic             rst,
  univ_shift_reg_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  logic [WIDTH-1:0] q_q,    q_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  dir_e             dir_q,  dir_d;
  logic             done_q, done_d;

  logic is_shift;
  dir_e shift_dir;

  // Decode whether this edge is a shift and in which direction.
  always_comb begin
    is_shift  = bus.en && (bus.mode == 2'b01 || bus.mode == 2'b10);
    shift_dir = (bus.mode == 2'b10) ? DIR_LEFT : DIR_RIGHT;
  end

  // Next-state: data path per mode, then frame counting on shift edges.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    done_d = 1'b0;

    if (bus.en) begin
      unique case (bus.mode)
        2'b00: q_d = q_q;
        2'b01: q_d = {bus.sin_r, q_q[WIDTH-1:1]};
        2'b10: q_d = {q_q[WIDTH-2:0], bus.sin_l};
        2'b11: begin
          q_d   = bus.pin;
          cnt_d = '0;
        end
      endcase
    end

    if (is_shift) begin
      // Reversing direction mid-frame discards the partial frame; this
      // shift becomes the first of a new one.
      if (cnt_q != '0 && shift_dir != dir_q) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      dir_d = shift_dir;
    end
  end

  // State registers; frame_done is rewritten every edge so it self-clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      dir_q  <= DIR_RIGHT;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      done_q <= done_d;
    end
  end

  assign bus.pout       = q_q;
  assign bus.sout_r     = q_q[0];
  assign bus.sout_l     = q_q[WIDTH-1];
  assign bus.shift_cnt  = cnt_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_univ_shift_reg;
  localparam int W = 4;

  logic clk;
  logic rst;

  univ_shift_reg_if #(.WIDTH(W)) ifc ();
  univ_shift_reg_if #(.WIDTH(W)) ifc2 ();

  univ_shift_reg #(.WIDTH(W), .RST_VAL(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  univ_shift_reg #(.WIDTH(W), .RST_VAL(4'hA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifc2)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: register as an integer, frame as a run length of
  // same-direction shifts since the last load, reset or completed frame.
  int m_q;
  int m_run;
  bit m_dir;   // 0 right, 1 left
  bit m_done;

  function automatic int run_after(input int run, input bit d, input bit last);
    if (run > 0 && d != last) return 1;
    return run + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= 0;
      m_run  <= 0;
      m_dir  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (ifc.en) begin
        if (ifc.mode == 2'b11) begin
          m_q   <= int'(ifc.pin);
          m_run <= 0;
        end else if (ifc.mode != 2'b00) begin
          bit d;
          int r;
          d = (ifc.mode == 2'b10);
          if (d) m_q <= ((m_q * 2) + int'(ifc.sin_l)) % (1 << W);
          else   m_q <= (m_q / 2) + int'(ifc.sin_r) * (1 << (W - 1));
          r = run_after(m_run, d, m_dir);
          if (r == W) begin
            m_run  <= 0;
            m_done <= 1'b1;
          end else begin
            m_run <= r;
          end
          m_dir <= d;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("pout",       32'(ifc.pout),       32'(m_q));
      chk("sout_r",     32'(ifc.sout_r),     32'(m_q % 2));
      chk("sout_l",     32'(ifc.sout_l),     32'((m_q >> (W - 1)) % 2));
      chk("shift_cnt",  32'(ifc.shift_cnt),  32'(m_run));
      chk("frame_done", 32'(ifc.frame_done), 32'(m_done));
    end
  end

  task automatic step(input logic e, input logic [1:0] m, input logic sr,
                      input logic sl, input logic [W-1:0] p);
    ifc.en    = e;
    ifc.mode  = m;
    ifc.sin_r = sr;
    ifc.sin_l = sl;
    ifc.pin   = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rbits;
    rbits = 4'b1101;   // applied LSB-first: sin_r = 1,0,1,1

    rst = 1'b0;
    ifc.en = 1'b0; ifc.mode = 2'b00; ifc.sin_r = 1'b0; ifc.sin_l = 1'b0; ifc.pin = '0;
    ifc2.en = 1'b0; ifc2.mode = 2'b00; ifc2.sin_r = 1'b0; ifc2.sin_l = 1'b0; ifc2.pin = '0;

    // Reset asserted between edges takes effect before the next edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_pout",   32'(ifc.pout),       32'h0);
    chk("rst_cnt",    32'(ifc.shift_cnt),  32'h0);
    chk("rst_done",   32'(ifc.frame_done), 32'h0);
    chk("rst_pout_A", 32'(ifc2.pout),      32'hA);
    @(posedge clk);
    #1 rst = 1'b0;
    cmp_on = 1'b1;

    // Serial-in right: 1,0,1,1.
    for (int i = 0; i < W; i++) step(1'b1, 2'b01, rbits[i], 1'b0, '0);
    chk("sipo_pout",   32'(ifc.pout),       32'hD);
    chk("sipo_done",   32'(ifc.frame_done), 32'h1);
    chk("sipo_sout_r", 32'(ifc.sout_r),     32'h1);
    step(1'b1, 2'b00, 1'b0, 1'b0, '0);
    chk("sipo_done_clr", 32'(ifc.frame_done), 32'h0);

    // Parallel in, serial out left.
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1001);
    chk("piso_sout_l0", 32'(ifc.sout_l), 32'h1);
    step(1'b1, 2'b10, 1'b0, 1'b0, '0);
    chk("piso_sout_l1", 32'(ifc.sout_l), 32'h0);
    step(1'b1, 2'b10, 1'b0, 1'b0, '0);
    chk("piso_sout_l2", 32'(ifc.sout_l), 32'h0);
    step(1'b1, 2'b10, 1'b0, 1'b0, '0);
    chk("piso_sout_l3", 32'(ifc.sout_l), 32'h1);
    chk("piso_nodone",  32'(ifc.frame_done), 32'h0);
    step(1'b1, 2'b10, 1'b0, 1'b0, '0);
    chk("piso_pout", 32'(ifc.pout),       32'h0);
    chk("piso_done", 32'(ifc.frame_done), 32'h1);

    // Direction change restarts the frame.
    step(1'b1, 2'b01, 1'b1, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b0, '0);
    chk("dir_cnt2", 32'(ifc.shift_cnt), 32'h2);
    step(1'b1, 2'b10, 1'b0, 1'b1, '0);
    chk("dir_cnt1",  32'(ifc.shift_cnt),  32'h1);
    chk("dir_done0", 32'(ifc.frame_done), 32'h0);
    step(1'b1, 2'b10, 1'b0, 1'b1, '0);
    step(1'b1, 2'b10, 1'b0, 1'b1, '0);
    chk("dir_done_pre", 32'(ifc.frame_done), 32'h0);
    step(1'b1, 2'b10, 1'b0, 1'b1, '0);
    chk("dir_done", 32'(ifc.frame_done), 32'h1);
    chk("dir_cnt0", 32'(ifc.shift_cnt),  32'h0);

    // Enable low holds; load mid-frame clears the count.
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 1'b0, 1'b0, '0);
    chk("en0_pout", 32'(ifc.pout),      32'hE);
    chk("en0_cnt",  32'(ifc.shift_cnt), 32'h3);
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b0101);
    chk("ld_pout", 32'(ifc.pout),       32'h5);
    chk("ld_cnt",  32'(ifc.shift_cnt),  32'h0);
    chk("ld_done", 32'(ifc.frame_done), 32'h0);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b0, 1'b0, '0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    chk("mrst_cnt", 32'(ifc.shift_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b01, 1'b1, 1'b0, '0);
      chk("mrst_nodone", 32'(ifc.frame_done), 32'h0);
    end
    step(1'b1, 2'b01, 1'b1, 1'b0, '0);
    chk("mrst_done", 32'(ifc.frame_done), 32'h1);
    chk("mrst_pout", 32'(ifc.pout),       32'hF);

    // Randomized traffic, with occasional asynchronous reset pulses.
    for (int i = 0; i < 1500; i++) begin
      logic       e;
      logic [1:0] m;
      e = ($urandom_range(0, 9) != 0);
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && m == 2'b11) m = 2'($urandom_range(1, 2));
      step(e, m, 1'($urandom), 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
